inst_fetch_unit: RTL and testbench

Instruction fetch unit sitting directly upstream of the instruction cache / memory controller. Holds the architectural fetch PC, issues one outstanding word request at a time to the cache, buffers returned instructions with their PC in a small FIFO, and presents them to the decoder over a valid/ready handshake. Supports pipeline redirect (flush) from the branch/commit logic and optional JAL pre-decode redirection.

---
 rtl/ifu_pkg.sv | 29 ++
 rtl/inst_fetch_unit_if.sv | 38 +++
 rtl/inst_fetch_unit_queue.sv | 104 ++++++++++
 rtl/inst_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared types and helpers for the instruction fetch unit.
//   ifu_state_e : fetch FSM states (IDLE, WAIT, DROP)
//   OPC_JAL     : RV32 JAL major opcode, used by the optional pre-decode
//   ENTRY_W     : width of one instruction queue entry (pc, instruction, pred)
//   ifu_entry_t : packed queue entry
//   j_imm()     : sign-extended J-type immediate of an instruction word
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifu_state_e;

    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam int         ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ifu_entry_t;

    // J-immediate: imm[20|10:1|11|19:12] lives in instr[31:12]; bit 0 is always zero.
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if -- bundle of the fetch unit's bus signals.
//   cache side  : fetch_req, fetch_addr (to cache); fetch_data, fetch_ready (from cache)
//   redirect    : redirect_valid, redirect_pc (from branch/commit logic)
//   decode side : inst_valid, inst_data, inst_pc, inst_pred_taken (to decoder); inst_ready (from decoder)
// Modports: master = the fetch unit, slave = its environment (cache, redirect source, decoder).
interface inst_fetch_unit_if;

    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_ready;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_pred_taken;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_data, fetch_ready,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, inst_pred_taken,
        input  inst_ready
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_data, fetch_ready,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, inst_pred_taken,
        output inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_queue.sv
// inst_queue -- synchronous FIFO of fetched instructions with a registered head.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : drop all entries (wins over push/pop)
//   push         : write push_entry at the tail (ignored when full)
//   pop          : remove the head (ignored when empty)
//   head_valid   : registered, queue not empty
//   head_entry   : registered copy of the head entry (zero when empty)
//   count        : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  ifu_entry_t               push_entry,
    input  logic                     pop,
    output logic                     head_valid,
    output ifu_entry_t               head_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    ifu_entry_t         mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_n_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_n_s;
    logic               head_valid_r;
    ifu_entry_t         head_entry_r;
    ifu_entry_t         head_n_s;
    logic               push_s;
    logic               pop_s;

    // Next pointer/count and the entry that will sit at the head after this edge.
    always_comb begin
        push_s     = push & (count_r != DEPTH_C);
        pop_s      = pop & head_valid_r;
        rd_ptr_n_s = rd_ptr_r;
        count_n_s  = count_r;
        head_n_s   = '0;

        if (pop_s) begin
            rd_ptr_n_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CNT_W'(1);
            2'b01:   count_n_s = count_r - CNT_W'(1);
            default: count_n_s = count_r;
        endcase

        // If the queue is empty once the pop is applied, the new head is the
        // entry being written now, which is not yet in mem_r.
        if (count_n_s == '0) begin
            head_n_s = '0;
        end else if (push_s && (count_r == (pop_s ? CNT_W'(1) : CNT_W'(0)))) begin
            head_n_s = push_entry;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            head_valid_r <= 1'b0;
            head_entry_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r     <= rd_ptr_n_s;
            count_r      <= count_n_s;
            head_valid_r <= (count_n_s != '0);
            head_entry_r <= head_n_s;
        end
    end

    // Entry storage; contents are only read when counted as valid, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    assign head_valid = head_valid_r;
    assign head_entry = head_entry_r;
    assign count      = count_r;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit -- holds the fetch PC, issues one outstanding word request at a
// time to the instruction cache, queues returned words with their PC and hands
// them to the decoder over valid/ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_fetch_unit_if.master (cache request/response, redirect, decode handshake)
// Parameters: RESET_PC (fetch PC after reset), QUEUE_DEPTH (power of two, 2..32).
// Build option: define IFU_JAL_REDIRECT_EN to follow JAL targets at push time
// and flag such entries with inst_pred_taken.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 8
)
(
    input  logic                   clk,
    input  logic                   rst,
    inst_fetch_unit_if.master      bus
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    ifu_state_e         state_r;
    ifu_state_e         state_n_s;
    logic [31:0]        pc_r;
    logic [31:0]        pc_n_s;
    logic               fetch_req_r;
    logic               req_n_s;
    logic [31:0]        fetch_addr_r;
    logic [31:0]        addr_n_s;
    logic [31:0]        redirect_pc_s;
    logic [31:0]        next_pc_s;
    logic               pred_s;
    logic               push_s;
    logic               flush_s;
    ifu_entry_t         push_entry_s;
    ifu_entry_t         head_entry_s;
    logic               head_valid_s;
    logic [CNT_W-1:0]   q_count_s;

`ifdef IFU_JAL_REDIRECT_EN
    // Pre-decode: a returning JAL steers the next fetch to its target.
    always_comb begin
        if (bus.fetch_data[6:0] == OPC_JAL) begin
            next_pc_s = pc_r + j_imm(bus.fetch_data);
            pred_s    = 1'b1;
        end else begin
            next_pc_s = pc_r + 32'd4;
            pred_s    = 1'b0;
        end
    end
`else
    // Sequential fetch only.
    always_comb begin
        next_pc_s = pc_r + 32'd4;
        pred_s    = 1'b0;
    end
`endif

    assign redirect_pc_s = {bus.redirect_pc[31:2], 2'b00};
    assign push_entry_s  = {pc_r, bus.fetch_data, pred_s};

    // Fetch FSM next state; a redirect overrides everything else in every state.
    always_comb begin
        state_n_s = state_r;
        pc_n_s    = pc_r;
        req_n_s   = fetch_req_r;
        addr_n_s  = fetch_addr_r;
        push_s    = 1'b0;
        flush_s   = 1'b0;

        if (bus.redirect_valid) begin
            flush_s = 1'b1;
            pc_n_s  = redirect_pc_s;
            req_n_s = 1'b0;
            // A request still in flight must have its response swallowed in DROP.
            case (state_r)
                WAIT, DROP: state_n_s = bus.fetch_ready ? IDLE : DROP;
                default:    state_n_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (q_count_s < DEPTH_C) begin
                        req_n_s   = 1'b1;
                        addr_n_s  = pc_r;
                        state_n_s = WAIT;
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                WAIT: begin
                    if (bus.fetch_ready) begin
                        push_s    = 1'b1;
                        pc_n_s    = next_pc_s;
                        req_n_s   = 1'b0;
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = WAIT;
                    end
                end
                DROP: begin
                    if (bus.fetch_ready) begin
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DROP;
                    end
                end
                default: begin
                    req_n_s   = 1'b0;
                    state_n_s = IDLE;
                end
            endcase
        end
    end

    // Fetch FSM state, PC and registered cache request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            fetch_req_r  <= 1'b0;
            fetch_addr_r <= RESET_PC;
        end else begin
            state_r      <= state_n_s;
            pc_r         <= pc_n_s;
            fetch_req_r  <= req_n_s;
            fetch_addr_r <= addr_n_s;
        end
    end

    inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush_s),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (bus.inst_ready),
        .head_valid (head_valid_s),
        .head_entry (head_entry_s),
        .count      (q_count_s)
    );

    assign bus.fetch_req       = fetch_req_r;
    assign bus.fetch_addr      = fetch_addr_r;
    assign bus.inst_valid      = head_valid_s;
    assign bus.inst_data       = head_entry_s.instr;
    assign bus.inst_pc         = head_entry_s.pc;
    assign bus.inst_pred_taken = head_entry_s.pred;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit (RESET_PC = 0x100, QUEUE_DEPTH = 8).
// A cache model answers one cycle after each request in auto mode; later
// scenarios drive fetch_ready by hand.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          QDEPTH   = 8;

`ifdef IFU_JAL_REDIRECT_EN
    localparam logic [31:0] EXP_A1   = 32'h0000_0110;
    localparam logic [31:0] EXP_PRED = 32'd1;
`else
    localparam logic [31:0] EXP_A1   = 32'h0000_0104;
    localparam logic [31:0] EXP_PRED = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (QDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          auto_en  = 1'b0;
    int          cache_wait = 0;
    int          nreq = 0;
    logic        prev_req = 1'b0;
    logic [31:0] req_addr [16];

    function automatic logic [31:0] word_for(input logic [31:0] addr);
        return {addr[15:0], 16'h1234};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, then update the cache model and request log.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        if (auto_en && bus.fetch_req && !bus.fetch_ready) begin
            if (cache_wait == 0) begin
                cache_wait = 1;
            end else begin
                bus.fetch_ready = 1'b1;
                bus.fetch_data  = word_for(bus.fetch_addr);
                cache_wait      = 0;
            end
        end else begin
            bus.fetch_ready = 1'b0;
            cache_wait      = 0;
        end
        if (bus.fetch_req && !prev_req) begin
            if (nreq < 16) req_addr[nreq] = bus.fetch_addr;
            nreq++;
        end
        prev_req = bus.fetch_req;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 12 && !bus.inst_valid; k++) tick();
        check_eq(tag, 32'(bus.inst_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 12 && !bus.fetch_req; k++) tick();
        check_eq(tag, 32'(bus.fetch_req), 32'd1);
    endtask

    initial begin
        bus.fetch_data     = 32'h0;
        bus.fetch_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        auto_en            = 1'b1;

        // Reset values
        tick();
        tick();
        check_eq("rst_req",   32'(bus.fetch_req), 32'd0);
        check_eq("rst_addr",  bus.fetch_addr, RESET_PC);
        check_eq("rst_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rst_data",  bus.inst_data, 32'h0);
        check_eq("rst_pc",    bus.inst_pc, 32'h0);
        check_eq("rst_pred",  32'(bus.inst_pred_taken), 32'd0);
        rst = 1'b0;

        // Sequential fetch with 1-cycle cache, decoder stalled
        tick();
        check_eq("c1_req",  32'(bus.fetch_req), 32'd1);
        check_eq("c1_addr", bus.fetch_addr, 32'h100);
        tick();
        check_eq("c2_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check_eq("c3_valid", 32'(bus.inst_valid), 32'd1);
        check_eq("c3_pc",    bus.inst_pc, 32'h100);
        check_eq("c3_data",  bus.inst_data, word_for(32'h100));
        check_eq("c3_req",   32'(bus.fetch_req), 32'd0);
        repeat (40) tick();
        check_eq("full_nreq", 32'(nreq), 32'd8);
        check_eq("addr_1",    req_addr[1], 32'h104);
        check_eq("addr_2",    req_addr[2], 32'h108);
        check_eq("addr_7",    req_addr[7], 32'h11C);
        check_eq("full_req",  32'(bus.fetch_req), 32'd0);
        check_eq("full_head", bus.inst_pc, 32'h100);

        // One pop frees one slot -> exactly one new request
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check_eq("pop_head", bus.inst_pc, 32'h104);
        repeat (20) tick();
        check_eq("refill_nreq", 32'(nreq), 32'd9);
        check_eq("refill_addr", req_addr[8], 32'h120);
        check_eq("refill_req",  32'(bus.fetch_req), 32'd0);

        // Drain in order while fetch keeps running
        for (int i = 0; i < 10; i++) begin
            wait_valid("drain_valid");
            check_eq("drain_pc",   bus.inst_pc, 32'h104 + 32'(4 * i));
            check_eq("drain_data", bus.inst_data, word_for(32'h104 + 32'(4 * i)));
            bus.inst_ready = 1'b1;
            tick();
            bus.inst_ready = 1'b0;
        end

        // Switch to manual cache control at a quiet cycle
        for (int k = 0; k < 12 && (bus.fetch_req || bus.fetch_ready); k++) tick();
        auto_en = 1'b0;
        wait_req("manual_req");

        // Redirect while waiting; response arrives two cycles later and is dropped
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2002;
        tick();
        check_eq("rdw_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rdw_req",   32'(bus.fetch_req), 32'd0);
        tick();
        check_eq("drop_req",  32'(bus.fetch_req), 32'd0);
        bus.fetch_ready = 1'b1;
        bus.fetch_data  = 32'hDEAD_BEEF;
        tick();
        check_eq("drop_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("drop_req2",  32'(bus.fetch_req), 32'd0);
        tick();
        check_eq("rdw_newreq",  32'(bus.fetch_req), 32'd1);
        check_eq("rdw_newaddr", bus.fetch_addr, 32'h2000);
        check_eq("rdw_empty",   32'(bus.inst_valid), 32'd0);

        // Redirect and response in the same cycle
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        bus.fetch_ready    = 1'b1;
        bus.fetch_data     = 32'h1111_1111;
        tick();
        check_eq("rdr_req",   32'(bus.fetch_req), 32'd0);
        check_eq("rdr_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check_eq("rdr_newreq",  32'(bus.fetch_req), 32'd1);
        check_eq("rdr_newaddr", bus.fetch_addr, 32'h100);
        check_eq("rdr_empty",   32'(bus.inst_valid), 32'd0);

        // JAL word at 0x100 (imm = +16)
        bus.fetch_ready = 1'b1;
        bus.fetch_data  = 32'h0100_006F;
        tick();
        check_eq("jal_valid", 32'(bus.inst_valid), 32'd1);
        check_eq("jal_pc",    bus.inst_pc, 32'h100);
        check_eq("jal_data",  bus.inst_data, 32'h0100_006F);
        check_eq("jal_pred",  32'(bus.inst_pred_taken), EXP_PRED);
        tick();
        check_eq("jal_req",  32'(bus.fetch_req), 32'd1);
        check_eq("jal_next", bus.fetch_addr, EXP_A1);

        // Build three entries, then push and pop together
        bus.fetch_ready = 1'b1;
        bus.fetch_data  = 32'h1111_0013;
        tick();
        tick();
        check_eq("a2_addr", bus.fetch_addr, EXP_A1 + 32'd4);
        bus.fetch_ready = 1'b1;
        bus.fetch_data  = 32'h2222_0013;
        tick();
        tick();
        check_eq("cnt3_pre", 32'(dut.q_count_s), 32'd3);
        bus.inst_ready  = 1'b1;
        bus.fetch_ready = 1'b1;
        bus.fetch_data  = 32'h3333_0013;
        tick();
        check_eq("pp_count", 32'(dut.q_count_s), 32'd3);
        check_eq("pp_pc1",   bus.inst_pc, EXP_A1);
        check_eq("pp_data1", bus.inst_data, 32'h1111_0013);
        check_eq("pp_pred1", 32'(bus.inst_pred_taken), 32'd0);
        tick();
        check_eq("pp_pc2",   bus.inst_pc, EXP_A1 + 32'd4);
        check_eq("pp_data2", bus.inst_data, 32'h2222_0013);
        tick();
        check_eq("pp_pc3",   bus.inst_pc, EXP_A1 + 32'd8);
        check_eq("pp_data3", bus.inst_data, 32'h3333_0013);
        tick();
        bus.inst_ready = 1'b0;
        check_eq("pp_empty", 32'(bus.inst_valid), 32'd0);

        // Redirect and pop in the same cycle: flush wins
        wait_req("a4_req");
        bus.fetch_ready = 1'b1;
        bus.fetch_data  = 32'h4444_0013;
        tick();
        check_eq("a4_valid", 32'(bus.inst_valid), 32'd1);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_4000;
        tick();
        bus.inst_ready = 1'b0;
        check_eq("rp_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rp_count", 32'(dut.q_count_s), 32'd0);
        check_eq("rp_req",   32'(bus.fetch_req), 32'd0);
        tick();
        check_eq("rp_newreq",  32'(bus.fetch_req), 32'd1);
        check_eq("rp_newaddr", bus.fetch_addr, 32'h4000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
